// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: dual write ports, dual read ports and clear-engine handshake.
// The master side drives requests; the slave side is the register file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              clr_req;
    logic              busy;
    logic              wr_drop;
    logic              wr_en0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [DATA_W-1:0] wr_data0;
    logic              wr_en1;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data1;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [ADDR_W-1:0] rd_addr_t;
    logic [DATA_W-1:0] rd_data_t;

    modport master (
        output clr_req, wr_en0, wr_addr0, wr_data0,
               wr_en1, wr_addr1, wr_data1, rd_addr_s, rd_addr_t,
        input  busy, wr_drop, rd_data_s, rd_data_t
    );

    modport slave (
        input  clr_req, wr_en0, wr_addr0, wr_data0,
               wr_en1, wr_addr1, wr_data1, rd_addr_s, rd_addr_t,
        output busy, wr_drop, rd_data_s, rd_data_t
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: 2 async read ports, 2 sync write ports, optional hardwired zero
// entry and a one-entry-per-cycle clear engine. Define REGFILE_MP_BYPASS_EN for write-to-read bypass.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              commit0, commit1;
    logic [ADDR_W-1:0] rdAddr [2];
    logic [DATA_W-1:0] rdData [2];

    always_comb begin
        commit0 = bus.wr_en0 && (state_q == IDLE) && ((ZERO_REG == 0) || (bus.wr_addr0 != '0));
        commit1 = bus.wr_en1 && (state_q == IDLE) && ((ZERO_REG == 0) || (bus.wr_addr1 != '0));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_drop_d = (state_q == CLEAR) && (bus.wr_en0 || bus.wr_en1);
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // Counter wraps to 0 on the same edge the engine returns to IDLE
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Port 1 is assigned last so it wins a same-address collision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (commit0) begin
                mem_q[bus.wr_addr0] <= bus.wr_data0;
            end
            if (commit1) begin
                mem_q[bus.wr_addr1] <= bus.wr_data1;
            end
        end
    end

    assign rdAddr[0] = bus.rd_addr_s;
    assign rdAddr[1] = bus.rd_addr_t;

    // Later assignments override: bypass, then zero entry, then reset
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdData[p] = mem_q[rdAddr[p]];
`ifdef REGFILE_MP_BYPASS_EN
            if (commit1 && (bus.wr_addr1 == rdAddr[p])) begin
                rdData[p] = bus.wr_data1;
            end else if (commit0 && (bus.wr_addr0 == rdAddr[p])) begin
                rdData[p] = bus.wr_data0;
            end
`endif
            if ((ZERO_REG != 0) && (rdAddr[p] == '0)) begin
                rdData[p] = '0;
            end
            if (reset) begin
                rdData[p] = '0;
            end
        end
    end

    assign bus.rd_data_s = rdData[0];
    assign bus.rd_data_t = rdData[1];
    assign bus.busy      = (state_q == CLEAR);
    assign bus.wr_drop   = wr_drop_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a ZERO_REG=1 and a ZERO_REG=0 instance share one stimulus
// stream; expected outputs from an array-based model are queued and checked by a monitor.
module tb_regfile_mp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic          rst;
        logic          clr;
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic [AW-1:0] ras;
        logic [AW-1:0] rat;
    } stim_t;

    typedef struct packed {
        logic [DW-1:0] s1;
        logic [DW-1:0] t1;
        logic [DW-1:0] s2;
        logic [DW-1:0] t2;
        logic          busy;
        logic          drop;
    } exp_t;

    logic clk = 1'b0;
    logic tbReset;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW)) ifc1 ();
    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW)) ifc2 ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut1 (
        .clk(clk), .reset(tbReset), .bus(ifc1.slave)
    );
    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut2 (
        .clk(clk), .reset(tbReset), .bus(ifc2.slave)
    );

    assign ifc2.clr_req   = ifc1.clr_req;
    assign ifc2.wr_en0    = ifc1.wr_en0;
    assign ifc2.wr_addr0  = ifc1.wr_addr0;
    assign ifc2.wr_data0  = ifc1.wr_data0;
    assign ifc2.wr_en1    = ifc1.wr_en1;
    assign ifc2.wr_addr1  = ifc1.wr_addr1;
    assign ifc2.wr_data1  = ifc1.wr_data1;
    assign ifc2.rd_addr_s = ifc1.rd_addr_s;
    assign ifc2.rd_addr_t = ifc1.rd_addr_t;

    always #5 clk = ~clk;

    // Reference model: mem[0] holds what a ZERO_REG=0 file would store there
    logic [DW-1:0] mMem [DEPTH];
    bit            mBusy;
    int            mClrIdx;
    bit            mDrop;
    stim_t         cur;
    exp_t          expQ [$];
    int            errors = 0;
    int            checks = 0;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, req);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
        mBusy   = 0;
        mClrIdx = 0;
        mDrop   = 0;
    endfunction

    // Effect of one rising edge given the inputs held during the preceding cycle
    function automatic void modelEdge(input stim_t s);
        bit dropNext;
        if (s.rst) return;
        dropNext = mBusy && (s.we0 || s.we1);
        if (mBusy) begin
            mMem[mClrIdx] = '0;
            mClrIdx++;
            if (mClrIdx == DEPTH) begin
                mBusy   = 0;
                mClrIdx = 0;
            end
        end else begin
            if (s.we0) mMem[s.wa0] = s.wd0;
            if (s.we1) mMem[s.wa1] = s.wd1;
            if (s.clr) begin
                mBusy   = 1;
                mClrIdx = 0;
            end
        end
        mDrop = dropNext;
    endfunction

    function automatic logic [DW-1:0] expRead(input stim_t s, input logic [AW-1:0] a, input bit zr);
        if (s.rst) return '0;
        if (zr && a == 0) return '0;
`ifdef REGFILE_MP_BYPASS_EN
        if (!mBusy) begin
            if (s.we1 && s.wa1 == a) return s.wd1;
            if (s.we0 && s.wa0 == a) return s.wd0;
        end
`endif
        return mMem[a];
    endfunction

    function automatic void driveBus(input stim_t s);
        tbReset        = s.rst;
        ifc1.clr_req   = s.clr;
        ifc1.wr_en0    = s.we0;
        ifc1.wr_addr0  = s.wa0;
        ifc1.wr_data0  = s.wd0;
        ifc1.wr_en1    = s.we1;
        ifc1.wr_addr1  = s.wa1;
        ifc1.wr_data1  = s.wd1;
        ifc1.rd_addr_s = s.ras;
        ifc1.rd_addr_t = s.rat;
    endfunction

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        modelEdge(cur);
        cur = s;
        driveBus(s);
        if (s.rst) modelReset();
        e.s1   = expRead(s, s.ras, 1);
        e.t1   = expRead(s, s.rat, 1);
        e.s2   = expRead(s, s.ras, 0);
        e.t2   = expRead(s, s.rat, 0);
        e.busy = s.rst ? 1'b0 : mBusy;
        e.drop = s.rst ? 1'b0 : mDrop;
        expQ.push_back(e);
    endtask

    function automatic stim_t rd(input int a, input int b);
        stim_t s = '0;
        s.ras = AW'(a);
        s.rat = AW'(b);
        return s;
    endfunction

    function automatic stim_t wr(input int p, input int a, input logic [DW-1:0] d, input int ra, input int rb);
        stim_t s = rd(ra, rb);
        if (p == 0) begin
            s.we0 = 1; s.wa0 = AW'(a); s.wd0 = d;
        end else begin
            s.we1 = 1; s.wa1 = AW'(a); s.wd1 = d;
        end
        return s;
    endfunction

    // Monitor: checks the response queued for this cycle, away from the active edge
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("rd_data_s_zr1", ifc1.rd_data_s, e.s1);
            checkOutput("rd_data_t_zr1", ifc1.rd_data_t, e.t1);
            checkOutput("rd_data_s_zr0", ifc2.rd_data_s, e.s2);
            checkOutput("rd_data_t_zr0", ifc2.rd_data_t, e.t2);
            checkOutput("busy_zr1", {31'b0, ifc1.busy}, {31'b0, e.busy});
            checkOutput("busy_zr0", {31'b0, ifc2.busy}, {31'b0, e.busy});
            checkOutput("wr_drop", {31'b0, ifc1.wr_drop}, {31'b0, e.drop});
        end
    end

    task automatic fillIndex();
        stim_t s;
        for (int i = 0; i < 16; i++) begin
            s = rd(i, 31 - i);
            s.we0 = 1; s.wa0 = AW'(2 * i);     s.wd0 = DW'(2 * i);
            s.we1 = 1; s.wa1 = AW'(2 * i + 1); s.wd1 = DW'(2 * i + 1);
            applyStimulus(s);
        end
    endtask

    initial begin
        stim_t s;
        modelReset();
        cur     = '0;
        cur.rst = 1;
        driveBus(cur);

        s = '0; s.rst = 1;
        applyStimulus(s);
        applyStimulus(s);

        applyStimulus(wr(0, 5, 32'hDEADBEEF, 5, 6));
        applyStimulus(rd(5, 6));
        applyStimulus(wr(1, 0, 32'h12345678, 0, 0));
        applyStimulus(rd(0, 5));

        s = wr(0, 3, 32'h11111111, 3, 4);
        s.we1 = 1; s.wa1 = 3; s.wd1 = 32'h22222222;
        applyStimulus(s);
        applyStimulus(rd(3, 4));
        s.wa1 = 4;
        applyStimulus(s);
        applyStimulus(rd(3, 4));

        applyStimulus(wr(0, 9, 32'h0BADF00D, 0, 9));
        applyStimulus(wr(1, 9, 32'hCAFEF00D, 5, 9));
        applyStimulus(rd(0, 9));

        fillIndex();
        s = rd(4, 20); s.clr = 1;
        applyStimulus(s);
        for (int c = 0; c < DEPTH + 2; c++) begin
            s = rd(4, 20);
            if (c == 3) s = wr(0, 7, 32'hAAAA5555, 7, 20);
            if (c == 8) s.clr = 1;
            applyStimulus(s);
        end
        for (int i = 0; i < 16; i++) applyStimulus(rd(2 * i, 2 * i + 1));

        fillIndex();
        s = rd(1, 2); s.clr = 1;
        applyStimulus(s);
        for (int c = 0; c < 5; c++) applyStimulus(rd(10, 30));
        s = rd(10, 30); s.rst = 1;
        applyStimulus(s);
        for (int i = 0; i < 4; i++) applyStimulus(rd(8 * i + 3, 8 * i + 7));

        // Randomised traffic with occasional clear and reset
        for (int n = 0; n < 400; n++) begin
            s     = '0;
            s.rst = ($urandom_range(0, 199) == 0);
            s.clr = ($urandom_range(0, 39) == 0);
            s.we0 = $urandom_range(0, 1) == 1;
            s.we1 = $urandom_range(0, 1) == 1;
            s.wa0 = AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            s.wa1 = AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            s.wd0 = $urandom;
            s.wd1 = $urandom;
            s.ras = $urandom_range(0, 1) == 1 ? s.wa0 : AW'($urandom_range(0, 31));
            s.rat = $urandom_range(0, 1) == 1 ? s.wa1 : AW'($urandom_range(0, 31));
            applyStimulus(s);
        end
        for (int c = 0; c < DEPTH + 1; c++) applyStimulus(rd(c, 31 - c));

        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parameterised multi-port register file for the integer datapath; next generation of the 32x32 single-write user register file.
- Provides two asynchronous read ports (S/T operands) and two synchronous write ports (dual-issue writeback).
- Adds a configurable hardwired-zero register and a sequenced bulk-clear engine with a busy flag.
- Same-cycle write-to-read bypass is optional.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1: 1 = entry 0 hardwired to zero and unwritable; 0 = entry 0 is an ordinary register.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- clr_req  in  1  request sequenced clear of all entries.
- busy  out  1  high while the clear sequencer runs.
- wr_drop  out  1  one-cycle pulse: a write was discarded because busy was high.
- wr_en0  in  1  write port 0 enable.
- wr_addr0  in  ADDR_W  write port 0 address.
- wr_data0  in  DATA_W  write port 0 data.
- wr_en1  in  1  write port 1 enable.
- wr_addr1  in  ADDR_W  write port 1 address.
- wr_data1  in  DATA_W  write port 1 data.
- rd_addr_s  in  ADDR_W  read port S address.
- rd_data_s  out  DATA_W  read port S data.
- rd_addr_t  in  ADDR_W  read port T address.
- rd_data_t  out  DATA_W  read port T data.

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. While reset is high:
  - all DEPTH entries are cleared to 0;
  - state = IDLE, clear counter = 0;
  - busy = 0, wr_drop = 0;
  - rd_data_s and rd_data_t are forced to 0.
- Reads: combinational, zero latency. rd_data_x = mem[rd_addr_x]. With ZERO_REG=1, address 0 always reads 0.
- Writes: committed on the rising clk edge when wr_enN=1 and state=IDLE.
  - With ZERO_REG=1, writes to address 0 are silently ignored; no wr_drop.
  - Both ports enabled to the same address: port 1 wins, port 0's data is lost; no wr_drop.
  - Different addresses: both commit in the same cycle.
- Without bypass, a read in the same cycle as a write returns the old value; the new value is visible from the next cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr_req=1 at an edge -> CLEAR, counter = 0. Writes presented in that same cycle still commit.
  - CLEAR: each edge writes mem[counter] = 0 and increments counter. When counter = DEPTH-1 that entry is cleared and the FSM returns to IDLE.
  - The clear takes exactly DEPTH cycles; busy = (state==CLEAR).
  - clr_req while in CLEAR is ignored; no restart.
- Reads during CLEAR return current contents: entries below counter read 0, the rest keep their old values.
- Writes during CLEAR are discarded. wr_drop is registered and goes high for one cycle after any edge where busy=1 and (wr_en0 | wr_en1).
- Reset asserted mid-CLEAR aborts the sequence immediately: all entries 0, IDLE, busy=0.
- The counter is ADDR_W bits; its wrap from DEPTH-1 to 0 coincides with the exit to IDLE.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: when a write port is committing this cycle (enabled, state IDLE, address non-zero or ZERO_REG=0) to the address being read, rd_data returns that write's data in the same cycle.
  - Port 1 has priority over port 0.
  - Reset forcing to 0 and address-0 zeroing take precedence over bypass.
  - Nothing is bypassed during CLEAR.
- Undefined: no bypass; a same-cycle read returns the old contents.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 5 via port 0; next cycle rd_addr_s=5 -> rd_data_s=0xDEADBEEF, rd_data_t (addr 6)=0.
- ZERO_REG=1: write 0x12345678 to addr 0 via port 1 -> rd_data at addr 0 = 0, wr_drop stays 0. Repeat with ZERO_REG=0 -> reads 0x12345678.
- Same cycle: port 0 writes 0x11111111 and port 1 writes 0x22222222, both to addr 3 -> addr 3 reads 0x22222222. Ports to addrs 3 and 4 -> both values stored.
- Fill addrs 1..31 with their index, pulse clr_req:
  - busy high for exactly 32 cycles;
  - at cycle 10 of CLEAR, addr 4 reads 0 and addr 20 reads 20;
  - after the sequence, all entries read 0.
- During CLEAR, assert wr_en0 to addr 7 with 0xAAAA5555 -> wr_drop pulses one cycle later; addr 7 reads 0 after the clear. Assert reset at CLEAR cycle 5 -> busy=0 immediately, all reads 0.
- With REGFILE_MP_BYPASS_EN defined: write 0xCAFEF00D to addr 9 while rd_addr_t=9 -> rd_data_t=0xCAFEF00D in the same cycle. Without the macro, rd_data_t shows the old value that cycle.
